// File: rtl/cp0_int_ctrl.sv
// CP0 for the P7 MIPS core: holds SR/Cause/EPC/PRId, arbitrates device interrupts and
// M-stage exceptions into one Req, and services mfc0/mtc0/eret.
module cp0_int_ctrl #(
  parameter logic [31:0] PRID_VAL   = 32'h0019_0701,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  RdAddr,
  input  logic [4:0]  WrAddr,
  input  logic        WE,
  input  logic [31:0] DIn,
  input  logic [31:0] PC,
  input  logic        BD,
  input  logic [4:0]  ExcCode,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] DOut,
  output logic        Req,
  output logic [31:0] EPCOut,
  output logic [31:0] HandlerPC
);

  localparam logic [4:0] AddrSr    = 5'd12;
  localparam logic [4:0] AddrCause = 5'd13;
  localparam logic [4:0] AddrEpc   = 5'd14;
  localparam logic [4:0] AddrPrid  = 5'd15;

  logic [5:0]  sr_im_q, sr_im_d;
  logic        sr_exl_q, sr_exl_d;
  logic        sr_ie_q, sr_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_ip_q, cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q, epc_d;

  logic        int_pend;
  logic        exc_pend;
  logic [31:0] epc_victim;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  always_comb begin
    int_pend   = (|(HWInt & sr_im_q)) & sr_ie_q & ~sr_exl_q;
    exc_pend   = (ExcCode != 5'd0) & ~sr_exl_q;
    Req        = int_pend | exc_pend;
    // Delay-slot faults restart at the branch so the branch is re-executed.
    epc_victim = BD ? (PC - 32'd4) : PC;
  end

  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_ip_d  = HWInt;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;

    if (Req) begin
      sr_exl_d    = 1'b1;
      cause_exc_d = int_pend ? 5'd0 : ExcCode;
      cause_bd_d  = BD;
      epc_d       = epc_victim & 32'hFFFF_FFFC;
    end else if (EXLClr) begin
      sr_exl_d = 1'b0;
    end else if (WE) begin
      case (WrAddr)
        AddrSr: begin
          sr_im_d  = DIn[15:10];
          sr_exl_d = DIn[1];
          sr_ie_d  = DIn[0];
        end
        AddrEpc: epc_d = DIn & 32'hFFFF_FFFC;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_im_q     <= '0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= '0;
      cause_exc_q <= '0;
      epc_q       <= '0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  always_comb begin
    sr_val    = {16'd0, sr_im_q, 8'd0, sr_exl_q, sr_ie_q};
    cause_val = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'd0};
    case (RdAddr)
      AddrSr:    DOut = sr_val;
      AddrCause: DOut = cause_val;
      AddrEpc:   DOut = epc_q;
      AddrPrid:  DOut = PRID_VAL;
      default:   DOut = 32'd0;
    endcase
    EPCOut    = epc_q;
    HandlerPC = HANDLER_PC;
  end

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Bench for cp0_int_ctrl: directed scenarios plus randomized traffic against a
// word-level reference model of SR/Cause/EPC.
module tb_cp0_int_ctrl;

  localparam logic [31:0] Prid = 32'h0019_0701;
  localparam logic [31:0] Hpc  = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  RdAddr, WrAddr, ExcCode;
  logic        WE, BD, EXLClr;
  logic [31:0] DIn, PC;
  logic [5:0]  HWInt;
  logic [31:0] DOut, EPCOut, HandlerPC;
  logic        Req;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_sr, m_cause, m_epc;

  always #10 clk = ~clk;

  cp0_int_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .RdAddr   (RdAddr),
    .WrAddr   (WrAddr),
    .WE       (WE),
    .DIn      (DIn),
    .PC       (PC),
    .BD       (BD),
    .ExcCode  (ExcCode),
    .HWInt    (HWInt),
    .EXLClr   (EXLClr),
    .DOut     (DOut),
    .Req      (Req),
    .EPCOut   (EPCOut),
    .HandlerPC(HandlerPC)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_int();
    return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic bit m_req();
    return m_int() || ((ExcCode != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return Prid;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_step();
    bit i, rq;
    i  = m_int();
    rq = m_req();
    if (!reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else begin
      if (rq) begin
        m_sr[1]      = 1'b1;
        m_cause[6:2] = i ? 5'd0 : ExcCode;
        m_cause[31]  = BD;
        m_epc        = (BD ? PC - 32'd4 : PC) & 32'hFFFF_FFFC;
      end else if (EXLClr) begin
        m_sr[1] = 1'b0;
      end else if (WE) begin
        if (WrAddr == 5'd12)      m_sr  = DIn & 32'h0000_FC03;
        else if (WrAddr == 5'd14) m_epc = DIn & 32'hFFFF_FFFC;
      end
      m_cause[15:10] = HWInt;
    end
  endtask

  // Called just after a negedge; checks outputs, takes one edge, returns at next negedge.
  task automatic tick(input string tag);
    #1;
    check({tag, "_req"}, {31'd0, Req}, {31'd0, m_req()});
    check({tag, "_dout"}, DOut, m_read(RdAddr));
    check({tag, "_epcout"}, EPCOut, m_epc);
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] exp);
    RdAddr = a;
    #1;
    check(tag, DOut, exp);
  endtask

  task automatic chk_req(input string tag, input logic exp);
    #1;
    check(tag, {31'd0, Req}, {31'd0, exp});
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    WE = 1'b1; WrAddr = a; DIn = d;
    tick("mtc0");
    WE = 1'b0;
  endtask

  task automatic eret();
    HWInt = 6'd0; ExcCode = 5'd0; BD = 1'b0; EXLClr = 1'b1;
    tick("eret");
    EXLClr = 1'b0;
  endtask

  initial begin
    reset = 1'b0; RdAddr = 5'd0; WrAddr = 5'd12; WE = 1'b1; DIn = 32'hFFFF_FFFF;
    PC = 32'd0; BD = 1'b0; ExcCode = 5'd0; HWInt = 6'h3F; EXLClr = 1'b0;
    m_sr = 0; m_cause = 0; m_epc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    peek("rst_sr", 5'd12, 32'd0);
    peek("rst_cause", 5'd13, 32'd0);
    peek("rst_epc", 5'd14, 32'd0);
    peek("rst_prid", 5'd15, Prid);
    check("rst_req", {31'd0, Req}, 32'd0);
    check("rst_epcout", EPCOut, 32'd0);
    check("handler_pc", HandlerPC, Hpc);

    reset = 1'b1; WE = 1'b0; HWInt = 6'd0;
    tick("idle");

    // Timer interrupt on HWInt[2].
    mtc0(5'd12, 32'h0000_0401);
    peek("tmr_sr0", 5'd12, 32'h0000_0401);
    HWInt = 6'b000001; PC = 32'h0000_3010; BD = 1'b0;
    chk_req("tmr_req", 1'b1);
    tick("tmr");
    peek("tmr_epc", 5'd14, 32'h0000_3010);
    peek("tmr_cause", 5'd13, 32'h0000_0400);
    peek("tmr_sr", 5'd12, 32'h0000_0403);
    chk_req("tmr_masked", 1'b0);

    // eret together with an SR write: write ignored, held interrupt fires again.
    EXLClr = 1'b1; WE = 1'b1; WrAddr = 5'd12; DIn = 32'd0;
    tick("eret_we");
    EXLClr = 1'b0; WE = 1'b0;
    peek("eret_sr", 5'd12, 32'h0000_0401);
    chk_req("eret_req", 1'b1);
    tick("tmr2");
    eret();

    // Interrupt and exception together: interrupt recorded as code 0.
    HWInt = 6'b000001; ExcCode = 5'd10; PC = 32'h0000_3040;
    tick("ivse");
    peek("ivse_cause", 5'd13, 32'h0000_0400);
    peek("ivse_epc", 5'd14, 32'h0000_3040);
    eret();

    // Exception in a delay slot.
    mtc0(5'd12, 32'h0000_0001);
    ExcCode = 5'd12; PC = 32'h0000_3024; BD = 1'b1;
    chk_req("ds_req", 1'b1);
    tick("ds");
    peek("ds_epc", 5'd14, 32'h0000_3020);
    peek("ds_cause", 5'd13, 32'h8000_0030);
    eret();

    // Masking by IM then by IE; IP still tracks the line.
    HWInt = 6'b000001;
    chk_req("mask_im_req", 1'b0);
    tick("mask_im");
    peek("mask_ip", 5'd13, 32'h8000_0430);
    mtc0(5'd12, 32'h0000_0400);
    chk_req("mask_ie_req", 1'b0);
    mtc0(5'd14, 32'h0000_3007);
    peek("epc_align", 5'd14, 32'h0000_3004);
    check("epc_align_out", EPCOut, 32'h0000_3004);

    // Reset beats a pending request.
    mtc0(5'd12, 32'h0000_0401);
    chk_req("rst_mid_req", 1'b1);
    reset = 1'b0;
    tick("rst_mid");
    reset = 1'b1; HWInt = 6'd0;
    peek("rst_mid_sr", 5'd12, 32'd0);
    peek("rst_mid_epc", 5'd14, 32'd0);
    chk_req("rst_mid_req0", 1'b0);

    for (int n = 0; n < 400; n++) begin
      reset   = ($urandom % 32) != 0;
      RdAddr  = ($urandom % 2 != 0) ? 5'(12 + $urandom % 4) : 5'($urandom % 32);
      WrAddr  = ($urandom % 2 != 0) ? 5'(12 + $urandom % 4) : 5'($urandom % 32);
      WE      = ($urandom % 3) == 0;
      DIn     = $urandom;
      PC      = $urandom & 32'hFFFF_FFFC;
      BD      = ($urandom % 2) != 0;
      ExcCode = ($urandom % 8 == 0) ? 5'($urandom % 32) : 5'd0;
      HWInt   = ($urandom % 4 == 0) ? 6'($urandom) : 6'd0;
      EXLClr  = ($urandom % 6) == 0;
      tick("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cp0_int_ctrl.md
Name: cp0_int_ctrl

Overview:
- Coprocessor-0 block for the P7 MIPS core.
- Consumes the timer/counter IRQ and the other device interrupt lines on HWInt[7:2]. The timer IRQ is wired to HWInt[2].
- Holds SR, Cause, EPC and PRId, and arbitrates interrupts and internal exceptions into a single Req to the pipeline.
- Services mfc0/mtc0 and handles eret (EXL clear). Sits beside the M stage and feeds the PC-select logic in F.

Parameters:
- PRID_VAL, 32'h0019_0701, constant returned on reads of register 15.
- HANDLER_PC, 32'h0000_4180, exception entry address driven on HandlerPC.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset; sampled on rising edge of clk
- RdAddr  in  5  CP0 register number for mfc0 read
- WrAddr  in  5  CP0 register number for mtc0 write
- WE  in  1  mtc0 write enable
- DIn  in  32  mtc0 write data
- PC  in  32  PC of the M-stage instruction, word aligned
- BD  in  1  M-stage instruction is in a branch delay slot
- ExcCode  in  5  internal exception code from M stage; 0 = none
- HWInt  in  6  level-sensitive device interrupt lines [7:2]
- EXLClr  in  1  eret in M stage
- DOut  out  32  read data for RdAddr (combinational)
- Req  out  1  take interrupt/exception this cycle (combinational)
- EPCOut  out  32  current EPC, used by eret
- HandlerPC  out  32  equals HANDLER_PC

Behaviour:
- Register fields:
  - SR (12): IM[15:10], EXL[1], IE[0]. All other bits read 0 and ignore writes.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]. All other bits read 0. Cause is not writable by mtc0.
  - EPC (14): 32 bits, bits[1:0] forced 0.
  - PRId (15): PRID_VAL.
  - Any other RdAddr reads 0.
- Reset (reset==0 at an edge): SR=0, Cause=0, EPC=0. Outputs after reset: DOut per RdAddr (0 except PRId), Req=0, EPCOut=0.
- IP update: Cause.IP <= HWInt every cycle unless reset. IP reflects the line one cycle late.
- Request decode (combinational, from current register state):
  - IntPend = |(HWInt & SR.IM) & SR.IE & !SR.EXL.
  - ExcPend = (ExcCode != 0) & !SR.EXL.
  - Req = IntPend | ExcPend.
- Priority, highest first: reset > Req > EXLClr > mtc0 write.
- On an edge with Req=1:
  - SR.EXL <= 1.
  - Cause.ExcCode <= IntPend ? 0 : ExcCode (interrupt wins over a simultaneous exception).
  - Cause.BD <= BD.
  - EPC <= BD ? (PC - 4) : PC, low 2 bits cleared.
  - WE and EXLClr in the same cycle are ignored.
- On an edge with EXLClr=1 and Req=0: SR.EXL <= 0. Other fields are unchanged, and a WE in the same cycle is ignored.
- On an edge with WE=1, Req=0, EXLClr=0:
  - WrAddr 12: SR <= DIn masked to IM/EXL/IE.
  - WrAddr 14: EPC <= {DIn[31:2],2'b00}.
  - Other addresses: no effect.
- Latency:
  - DOut is combinational from the registers; a write is visible on DOut the cycle after the edge.
  - Req is asserted in the same cycle the conditions hold.
  - After the EXL-setting edge, Req drops to 0 (EXL masks further requests).
- Reset mid-operation: reset overrides Req. EXL is cleared and EPC is zeroed even if a request is pending at that edge.
- Pipeline contract: while EXL=1, ExcCode and HWInt remain recorded in IP but produce no Req. Nested exceptions are not supported.

Test Plan:
- Reset: hold reset=0 for 2 edges with HWInt=6'h3F, WE=1 → SR=0, Cause=0, EPC=0, Req=0; RdAddr=15 gives DOut=32'h0019_0701.
- Timer interrupt:
  - mtc0 SR=32'h0000_0401 (IM[2]=1, IE=1); set HWInt=6'b000001, PC=32'h0000_3010, BD=0.
  - Expect Req=1 that cycle. After the edge: EPC=32'h0000_3010, Cause.ExcCode=0, SR.EXL=1, Req=0.
  - Cause reads 32'h0000_0400 while HWInt is held.
- Delay-slot exception: SR=32'h0000_0001, ExcCode=5'd12, PC=32'h0000_3024, BD=1 → Req=1; after the edge EPC=32'h0000_3020, Cause=32'h8000_0030.
- Interrupt vs exception same cycle: IM[2]=1, IE=1, HWInt[2]=1, ExcCode=5'd10 → recorded ExcCode=0.
- eret with mtc0 in the same cycle: EXL=1, EXLClr=1, WE=1 to SR with DIn=0 → EXL=0, IM/IE unchanged; a pending masked interrupt now raises Req.
- Masking: IE=0 or IM[2]=0 with HWInt[2]=1 → Req=0, Cause.IP[10]=1 after 1 cycle; writing EPC=32'h0000_3007 reads back 32'h0000_3004.
